// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: fixed-priority (D over I) merge of two single-beat read
// request ports onto one AXI AR/R channel pair, one transaction in flight.
module axi_rd_arbiter #(
  parameter logic [3:0] ID_INST = 4'd0,
  parameter logic [3:0] ID_DATA = 4'd1
) (
  input  logic        clk,
  input  logic        resetn,
  // data port
  input  logic [31:0] d_araddr,
  input  logic        d_arvalid,
  output logic        d_arready,
  output logic [31:0] d_rdata,
  output logic        d_rvalid,
  input  logic        d_rready,
  // instruction port
  input  logic [31:0] i_araddr,
  input  logic        i_arvalid,
  output logic        i_arready,
  output logic [31:0] i_rdata,
  output logic        i_rvalid,
  input  logic        i_rready,
  // AXI read address channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  // AXI read data channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // sticky error
  output logic        err_rid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] addr_q;
  logic        gnt_d_q;
  logic        arvalid_q;
  logic        err_rid_q;

  logic        in_idle;
  logic        in_data;
  logic [3:0]  gnt_id;
  logic        rid_match;
  logic        port_rready;
  logic        r_hs;

  // rresp carries no information this block acts on
  logic        unused_rresp;
  assign unused_rresp = ^rresp;

  assign arlen   = '0;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;

  assign arvalid = arvalid_q;
  assign araddr  = addr_q;
  assign arid    = gnt_id;
  assign err_rid = err_rid_q;

  assign d_rdata = rdata;
  assign i_rdata = rdata;

  // Decode current grant, ID match and port-side handshakes
  always_comb begin
    in_idle     = resetn & (state_q == IDLE);
    in_data     = resetn & (state_q == DATA);
    gnt_id      = gnt_d_q ? ID_DATA : ID_INST;
    rid_match   = (rid == gnt_id);
    port_rready = gnt_d_q ? d_rready : i_rready;

    d_arready   = in_idle & d_arvalid;
    i_arready   = in_idle & i_arvalid & ~d_arvalid;

    d_rvalid    = in_data &  gnt_d_q & rvalid & rid_match;
    i_rvalid    = in_data & ~gnt_d_q & rvalid & rid_match;

    // beats with a foreign ID are drained unconditionally
    rready      = in_data & (rid_match ? port_rready : 1'b1);
    r_hs        = rvalid & rready;
  end

  // Request/response sequencing with registered AR outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      gnt_d_q   <= 1'b1;
      arvalid_q <= 1'b0;
      err_rid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (d_arvalid) begin
            addr_q    <= d_araddr;
            gnt_d_q   <= 1'b1;
            arvalid_q <= 1'b1;
            state_q   <= ADDR;
          end else if (i_arvalid) begin
            addr_q    <= i_araddr;
            gnt_d_q   <= 1'b0;
            arvalid_q <= 1'b1;
            state_q   <= ADDR;
          end
        end
        ADDR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (r_hs) begin
            if (!rid_match) begin
              err_rid_q <= 1'b1;
            end else if (rlast) begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          arvalid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
